// File: rtl/time_of_day_counter.sv
// rtl/time_of_day_counter.sv - 24-hour BCD time-of-day counter with validated load and day rollover pulse
module time_of_day_counter #(
    parameter logic [7:0] RESET_HH = 8'h00,
    parameter logic [7:0] RESET_MM = 8'h00,
    parameter logic [7:0] RESET_SS = 8'h00
) (
    input  logic       clk_50Mhz,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       run,
    input  logic       load,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    output logic [7:0] hh_bcd,
    output logic [7:0] mm_bcd,
    output logic [7:0] ss_bcd,
    output logic       day_tick,
    output logic       load_err
);

    // Once both nibbles are known to be decimal, packed BCD orders like the value it encodes.
    function automatic logic bcd_in_range(input logic [7:0] v, input logic [7:0] max_v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max_v);
    endfunction

    logic       load_ok;
    logic       advance;
    logic [7:0] ss_next;
    logic [7:0] mm_next;
    logic [7:0] hh_next;
    logic       ss_wrap;
    logic       mm_wrap;
    logic       hh_wrap;

    assign load_ok = bcd_in_range(load_hh, 8'h23) &&
                     bcd_in_range(load_mm, 8'h59) &&
                     bcd_in_range(load_ss, 8'h59);
    assign advance = tick_1hz && run;

    always_comb begin
        ss_next = ss_bcd;
        mm_next = mm_bcd;
        hh_next = hh_bcd;
        ss_wrap = 1'b0;
        mm_wrap = 1'b0;
        hh_wrap = 1'b0;

        if (ss_bcd[3:0] == 4'd9) begin
            ss_next[3:0] = 4'd0;
            if (ss_bcd[7:4] == 4'd5) begin
                ss_next[7:4] = 4'd0;
                ss_wrap      = 1'b1;
            end else begin
                ss_next[7:4] = ss_bcd[7:4] + 4'd1;
            end
        end else begin
            ss_next[3:0] = ss_bcd[3:0] + 4'd1;
        end

        if (ss_wrap) begin
            if (mm_bcd[3:0] == 4'd9) begin
                mm_next[3:0] = 4'd0;
                if (mm_bcd[7:4] == 4'd5) begin
                    mm_next[7:4] = 4'd0;
                    mm_wrap      = 1'b1;
                end else begin
                    mm_next[7:4] = mm_bcd[7:4] + 4'd1;
                end
            end else begin
                mm_next[3:0] = mm_bcd[3:0] + 4'd1;
            end
        end

        // Hours wrap at 23 rather than at a digit boundary, so that case is tested first.
        if (mm_wrap) begin
            if (hh_bcd == 8'h23) begin
                hh_next = 8'h00;
                hh_wrap = 1'b1;
            end else if (hh_bcd[3:0] == 4'd9) begin
                hh_next[3:0] = 4'd0;
                hh_next[7:4] = hh_bcd[7:4] + 4'd1;
            end else begin
                hh_next[3:0] = hh_bcd[3:0] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_50Mhz or negedge rst_n) begin
        if (!rst_n) begin
            hh_bcd   <= RESET_HH;
            mm_bcd   <= RESET_MM;
            ss_bcd   <= RESET_SS;
            day_tick <= 1'b0;
            load_err <= 1'b0;
        end else begin
            day_tick <= 1'b0;
            load_err <= 1'b0;
            // A load always consumes the cycle; a coincident tick is dropped even if the load is rejected.
            if (load) begin
                if (load_ok) begin
                    hh_bcd <= load_hh;
                    mm_bcd <= load_mm;
                    ss_bcd <= load_ss;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (advance) begin
                hh_bcd   <= hh_next;
                mm_bcd   <= mm_next;
                ss_bcd   <= ss_next;
                day_tick <= hh_wrap;
            end
        end
    end

endmodule

// File: doc/time_of_day_counter.md
# time_of_day_counter

Time-of-day counter that consumes the single-cycle 1 Hz tick from the 1 Hz generator and keeps hours, minutes and seconds in packed BCD (24-hour format) for the display stage. It accepts a validated load of a new time, supports pausing, and emits a one-cycle day-rollover pulse for a downstream calendar stage. Everything runs on the 50 MHz system clock; the tick is an enable, not a clock.

## Interface
Parameters:
- RESET_HH, 8'h00, BCD hours value loaded on reset (must be valid, ≤ 23)
- RESET_MM, 8'h00, BCD minutes value loaded on reset (≤ 59)
- RESET_SS, 8'h00, BCD seconds value loaded on reset (≤ 59)

Ports:
- clk_50Mhz  input  1  system clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- tick_1hz  input  1  one-cycle pulse per second from the 1 Hz generator
- run  input  1  1 = count ticks, 0 = ticks ignored (time held)
- load  input  1  one-cycle request to load load_hh/mm/ss
- load_hh  input  8  BCD hours {tens,units}
- load_mm  input  8  BCD minutes
- load_ss  input  8  BCD seconds
- hh_bcd  output  8  current hours, registered
- mm_bcd  output  8  current minutes, registered
- ss_bcd  output  8  current seconds, registered
- day_tick  output  1  one-cycle pulse on 23:59:59 → 00:00:00 rollover
- load_err  output  1  one-cycle pulse when a load is rejected

## Operation
- Reset: hh/mm/ss = RESET_HH/MM/SS, day_tick = 0, load_err = 0.
- Priority per cycle: load > tick. A tick arriving in the same cycle as load is discarded (not deferred).
- Load validation: each nibble ≤ 9; load_ss ≤ 8'h59, load_mm ≤ 8'h59, load_hh ≤ 8'h23.
  - Valid: all three registers take the load values; load_err = 0. Loading is allowed regardless of run.
  - Invalid: time unchanged; load_err = 1 for one cycle; the coincident tick is still discarded.
- Counting (tick_1hz = 1, run = 1, load = 0):
  - ss units +1; 9 → 0 carries into ss tens; ss 59 → 00 carries into mm.
  - mm follows the same rule; mm 59 → 00 carries into hh.
  - hh units wrap 9 → 0 with tens +1; hh 23 → 00 asserts day_tick.
- run = 0: ticks ignored, no state change, day_tick stays 0.
- Arithmetic: per-digit BCD increment only. No binary add on packed bytes. Outputs never hold a non-BCD or out-of-range value.
- day_tick and load_err are registered and high for exactly one cycle. Otherwise 0.

## Timing
- The tick is sampled at rising edge N. New time, day_tick and load_err are visible from edge N until edge N+1. Latency is 1 cycle from input to output.
- A load at edge N: the new time is visible after edge N. The next tick can advance it as early as edge N+1.
- day_tick goes high in the same cycle that outputs first read 00:00:00.
- Back-to-back ticks on consecutive cycles are legal. Each tick advances exactly one second.
- Asynchronous rst_n assertion mid-count forces reset values immediately and clears any pending pulses. After deassertion, the first tick counts from the reset values.

## Test plan
- Reset with defaults → outputs 00:00:00, day_tick = 0, load_err = 0. Then 3 ticks → ss_bcd = 8'h03.
- Load 8'h12/8'h34/8'h58, then 2 ticks → 12:34:59, then 12:35:00. Also load 09:59:59 and tick → 10:00:00.
- Load 23:59:59, then tick → 00:00:00 with day_tick = 1 for exactly one cycle. Next cycle day_tick = 0.
- Load ss = 8'h60, then separately hh = 8'h24, then mm = 8'h3A → each load gives load_err one-cycle pulse and time unchanged.
- From 05:00:10, assert load 07:07:07 and tick in the same cycle → 07:07:07, not 07:07:08. With run = 0, 5 ticks → no change.
- Assert rst_n low mid-count at 01:02:03 between edges → outputs go to reset values without waiting for a clock edge. After release, tick → 00:00:01.
